// File: rtl/ai_tank_scheduler.sv
// ai_tank_scheduler
//   Enemy AI controller for N_TANKS tanks. A 16-bit Galois LFSR supplies
//   random draws. At the end of every decision period each tank in turn
//   gets a weighted random direction, a move flag and a fire flag. Fire is
//   limited by a per-tank cooldown. A tank that is moving while its
//   blocked line is high is flagged pending. On an idle cycle with no
//   period tick, the lowest pending tank gets a new direction, which is
//   forced to differ from its current direction.
//
// Ports
//   Clk          in   1          system clock
//   Reset_h      in   1          synchronous active-high reset
//   enable       in   1          1 = scheduling runs, 0 = freeze counter/commands
//   period       in   CNT_W      decision interval in cycles minus 1
//   blocked      in   N_TANKS    tank i hit an obstacle (level)
//   ai_ctrl      out  4*N_TANKS  tank i command at [4i+3:4i] = {fire,move,dir[1:0]}
//   decide_pulse out  1          one-cycle strobe when a full round completes
module ai_tank_scheduler #(
  parameter int          N_TANKS = 4,
  parameter int          CNT_W   = 32,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          W_S     = 11,
  parameter int          W_A     = 7,
  parameter int          W_D     = 7,
  parameter int          FIRE_CD = 3
) (
  input  logic                 Clk,
  input  logic                 Reset_h,
  input  logic                 enable,
  input  logic [CNT_W-1:0]     period,
  input  logic [N_TANKS-1:0]   blocked,
  output logic [4*N_TANKS-1:0] ai_ctrl,
  output logic                 decide_pulse
);

  localparam int IDX_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUND  = 2'd1;
  localparam logic [1:0] ST_REROLL = 2'd2;

  // Cumulative thresholds for the 5-bit direction draw (S, A, D, then W).
  localparam logic [5:0] TH_S = 6'(W_S);
  localparam logic [5:0] TH_A = 6'(W_S + W_A);
  localparam logic [5:0] TH_D = 6'(W_S + W_A + W_D);

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [1:0] dir_map(input logic [4:0] r);
    logic [5:0] rr;
    rr = {1'b0, r};
    if (rr < TH_S)      return 2'b10;
    else if (rr < TH_A) return 2'b01;
    else if (rr < TH_D) return 2'b00;
    else                return 2'b11;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_TANKS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_TANKS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  logic [15:0]          lfsr_q, lfsr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*N_TANKS-1:0] ctrl_q, ctrl_d;
  logic [3:0]           cd_q [N_TANKS];
  logic [3:0]           cd_d [N_TANKS];
  logic [N_TANKS-1:0]   pend_q, pend_d;
  logic                 pulse_q, pulse_d;

  logic [1:0]         draw_dir;
  logic               draw_move;
  logic               draw_fire;
  logic [N_TANKS-1:0] move_bits;
  logic [N_TANKS-1:0] pend_set;
  logic [N_TANKS-1:0] pend_clr;
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [1:0]         wr_dir;
  logic               wr_move;
  logic [1:0]         cur_dir;
  logic [3:0]         cd_cur;
  logic               fire;

  assign draw_dir  = dir_map(lfsr_q[4:0]);
  assign draw_move = lfsr_q[5] | lfsr_q[6];
  assign draw_fire = lfsr_q[7];

  always_comb begin
    lfsr_d   = lfsr_step(lfsr_q);
    cnt_d    = cnt_q;
    state_d  = state_q;
    idx_d    = idx_q;
    ctrl_d   = ctrl_q;
    cd_d     = cd_q;
    pulse_d  = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_dir   = draw_dir;
    wr_move  = draw_move;
    cur_dir  = 2'b00;
    cd_cur   = 4'd0;
    fire     = 1'b0;
    pend_clr = '0;

    move_bits = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      move_bits[i] = ctrl_q[4*i+2];
    end
    pend_set = blocked & move_bits;

    case (state_q)
      ST_IDLE: begin
        // The counter only advances while idle and enabled; a tick beats
        // any pending obstacle re-roll.
        if (enable) begin
          if (cnt_q == period) begin
            cnt_d   = '0;
            state_d = ST_ROUND;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (|pend_q) state_d = ST_REROLL;
          end
        end
      end
      ST_ROUND: begin
        wr_en  = 1'b1;
        wr_idx = idx_q;
        if (idx_q == IDX_W'(N_TANKS - 1)) begin
          state_d = ST_IDLE;
          pulse_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_REROLL: begin
        wr_en   = 1'b1;
        wr_idx  = lowest_set(pend_q);
        cur_dir = ctrl_q[4*wr_idx +: 2];
        // A re-roll must turn the tank away from whatever it is facing.
        if (draw_dir == cur_dir) wr_dir = draw_dir ^ 2'b01;
        wr_move = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      cd_cur = cd_q[wr_idx];
      fire   = draw_fire & (cd_cur == 4'd0);
      if (fire)                cd_d[wr_idx] = 4'(FIRE_CD);
      else if (cd_cur != 4'd0) cd_d[wr_idx] = cd_cur - 4'd1;
      ctrl_d[4*wr_idx +: 4] = {fire, wr_move, wr_dir};
      pend_clr[wr_idx]      = 1'b1;
    end

    // A write in the same cycle as a new blocked hit wins: the fresh
    // command supersedes the stale one that collided.
    pend_d = (pend_q | pend_set) & ~pend_clr;
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ctrl_q  <= '0;
      pend_q  <= '0;
      pulse_q <= 1'b0;
      for (int i = 0; i < N_TANKS; i++) cd_q[i] <= 4'd0;
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_TANKS; i++) cd_q[i] <= cd_d[i];
    end
  end

  assign ai_ctrl      = ctrl_q;
  assign decide_pulse = pulse_q;

endmodule

// File: tb/tb_ai_tank_scheduler.sv
module tb_ai_tank_scheduler;

  localparam int N  = 4;
  localparam int CD = 3;

  logic        Clk = 1'b0;
  logic        Reset_h = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic [3:0]  blocked = 4'd0;
  logic [15:0] ai_ctrl;
  logic        decide_pulse;

  always #5 Clk = ~Clk;

  ai_tank_scheduler #(
    .N_TANKS(N), .CNT_W(32), .SEED(16'hACE1),
    .W_S(11), .W_A(7), .W_D(7), .FIRE_CD(CD)
  ) dut (
    .Clk(Clk), .Reset_h(Reset_h), .enable(enable), .period(period),
    .blocked(blocked), .ai_ctrl(ai_ctrl), .decide_pulse(decide_pulse)
  );

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model, advanced on each rising edge ----------
  typedef struct {
    int          cyc;
    logic [15:0] ctrl;
    bit          pulse;
  } exp_t;
  exp_t sbq[$];

  int          cyc = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [31:0] m_cnt = 0;
  int          m_state = 0;
  int          m_idx = 0;
  logic [15:0] m_ctrl = 16'h0;
  int          m_cd[N];
  logic [3:0]  m_pend = 4'h0;
  bit          m_pulse = 1'b0;

  function automatic logic [1:0] ref_dir(input int r);
    if (r < 11) return 2'b10;
    if (r < 18) return 2'b01;
    if (r < 25) return 2'b00;
    return 2'b11;
  endfunction

  always @(posedge Clk) begin : model
    logic [15:0] prev, cur;
    logic [3:0]  pset, old_pend;
    logic [1:0]  d;
    bit          mv, fr, f, wr;
    int          w;
    cyc++;
    prev = m_ctrl;
    if (Reset_h) begin
      m_lfsr = 16'hACE1; m_cnt = 0; m_state = 0; m_idx = 0;
      m_ctrl = 16'h0; m_pend = 4'h0; m_pulse = 1'b0;
      for (int i = 0; i < N; i++) m_cd[i] = 0;
    end else begin
      cur = m_lfsr;
      d  = ref_dir(int'(cur[4:0]));
      mv = cur[5] | cur[6];
      fr = cur[7];
      for (int i = 0; i < N; i++) pset[i] = blocked[i] & m_ctrl[4*i+2];
      old_pend = m_pend;
      m_pulse = 1'b0;
      wr = 1'b0;
      w = 0;
      if (m_state == 0) begin
        if (enable) begin
          if (m_cnt == period) begin m_cnt = 0; m_state = 1; m_idx = 0; end
          else begin
            m_cnt = m_cnt + 1;
            if (old_pend != 0) m_state = 2;
          end
        end
        m_pend = old_pend | pset;
      end else if (m_state == 1) begin
        w = m_idx; wr = 1'b1;
        if (m_idx == N - 1) begin m_state = 0; m_pulse = 1'b1; end
        else m_idx = m_idx + 1;
      end else begin
        for (int i = N - 1; i >= 0; i--) if (old_pend[i]) w = i;
        if (d == m_ctrl[4*w +: 2]) d = d ^ 2'b01;
        mv = 1'b1; wr = 1'b1; m_state = 0;
      end
      if (wr) begin
        f = fr && (m_cd[w] == 0);
        if (f) m_cd[w] = CD;
        else if (m_cd[w] > 0) m_cd[w] = m_cd[w] - 1;
        m_ctrl[4*w +: 4] = {f, mv, d};
        m_pend = (old_pend | pset) & ~(4'b0001 << w);
      end
      m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    if (m_ctrl != prev || m_pulse) sbq.push_back('{cyc, m_ctrl, m_pulse});
  end

  // ---------------- monitor: pops on every visible DUT output event ---------
  logic [15:0] prev_dut = 16'h0;

  always @(negedge Clk) begin : monitor
    bit   trig;
    exp_t e;
    if (mon_on) begin
      while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        e = sbq.pop_front();
        tests++; fails++;
        $display("FAIL sb_missed: cycle %0d ctrl %0h pulse %0b never seen", e.cyc, e.ctrl, e.pulse);
      end
      trig = (ai_ctrl != prev_dut) || decide_pulse;
      if (trig) begin
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          e = sbq.pop_front();
          check("sb_ctrl", ai_ctrl, e.ctrl);
          check("sb_pulse", decide_pulse, e.pulse);
        end else begin
          tests++; fails++;
          $display("FAIL sb_unexpected: cycle %0d got ctrl %0h pulse %0b, required no event", cyc, ai_ctrl, decide_pulse);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        e = sbq.pop_front();
        tests++; fails++;
        $display("FAIL sb_missing: cycle %0d got ctrl %0h pulse 0, required ctrl %0h pulse %0b", cyc, ai_ctrl, e.ctrl, e.pulse);
      end
      prev_dut = ai_ctrl;
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic wait_pulse(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge Clk);
      if (decide_pulse) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL pulse_timeout: no decide_pulse within %0d cycles, required one", bound);
    end
  endtask

  task automatic reset_pulse();
    Reset_h = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_ctrl", ai_ctrl, 16'h0000);
    check("rst_pulse", decide_pulse, 1'b0);
    Reset_h = 1'b0;
  endtask

  // First round after reset with seed ACE1 and period 9: the tick falls in
  // cycle 9, tanks draw from LFSR states 30B1, AC58, 562C, 2B16 in cycles
  // 10..13, giving tank commands D, 4, 5, 0.
  function automatic logic [15:0] hand_exp(input int k);
    case (k)
      10:      return 16'h0000;
      11:      return 16'h000D;
      12:      return 16'h004D;
      default: return 16'h054D;
    endcase
  endfunction

  task automatic hand_round();
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      if (k >= 10) begin
        check($sformatf("hand_ctrl_c%0d", k), ai_ctrl, hand_exp(k));
        check($sformatf("hand_pulse_c%0d", k), decide_pulse, (k == 14));
      end
    end
  endtask

  // ---------------- main sequence ------------------------------------------
  longint hist[4];
  longint total;
  longint dev;
  bit     ok;
  bit     found;
  logic [15:0] snap;
  logic [15:0] frz;

  initial begin
    Reset_h = 1'b1; enable = 1'b1; period = 32'd9; blocked = 4'd0;
    repeat (3) @(negedge Clk);
    mon_on = 1'b1;
    sbq.delete();
    check("rst_ctrl_init", ai_ctrl, 16'h0000);
    check("rst_pulse_init", decide_pulse, 1'b0);
    Reset_h = 1'b0;
    hand_round();

    // Second round starts its writes in cycle 24; reset lands mid-round.
    repeat (11) @(negedge Clk);
    reset_pulse();
    hand_round();

    // Distribution: period 0, 8192 rounds of 4 decisions each.
    period = 32'd0;
    for (int d = 0; d < 4; d++) hist[d] = 0;
    for (int r = 0; r < 8192; r++) begin
      if (r > 0) begin
        wait_pulse(20, ok);
        if (!ok) break;
      end
      for (int t = 0; t < N; t++) hist[ai_ctrl[4*t +: 2]]++;
    end
    total = hist[0] + hist[1] + hist[2] + hist[3];
    check("dist_total", total, 32768);
    for (int d = 0; d < 4; d++) begin
      dev = 32 * hist[d] - ((d == 2) ? 11 : 7) * total;
      if (dev < 0) dev = -dev;
      check($sformatf("dist_dir%0d_within_2pct", d), (100 * dev < 64 * total), 1'b1);
    end

    // Obstacle: find a round leaving tank 2 moving south, then block it.
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      wait_pulse(20, ok);
      if (!ok) break;
      if (ai_ctrl[10:8] == 3'b110) found = 1'b1;
    end
    check("blk_found_tank2_south", found, 1'b1);
    if (found) begin
      period = 32'd40;
      snap = m_ctrl;
      @(negedge Clk);
      blocked = 4'b0100;
      @(negedge Clk);
      blocked = 4'b0000;
      repeat (2) @(negedge Clk);
      check("blk_move", ai_ctrl[10], 1'b1);
      check("blk_dir_changed", (ai_ctrl[9:8] != 2'b10), 1'b1);
      check("blk_others", {ai_ctrl[15:12], ai_ctrl[7:0]}, {snap[15:12], snap[7:0]});
      wait_pulse(100, ok);
    end

    // Tick vs pending with period 0: block every tank as the tick fires.
    period = 32'd0;
    blocked = 4'hF;
    @(negedge Clk);
    blocked = 4'h0;
    wait_pulse(20, ok);

    // Freeze: run the counter to 3, disable for 100 cycles, then resume.
    period = 32'd7;
    repeat (3) @(negedge Clk);
    enable = 1'b0;
    frz = m_ctrl;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      blocked = (i == 50) ? 4'hF : 4'h0;
      check("frz_ctrl", ai_ctrl, frz);
      check("frz_pulse", decide_pulse, 1'b0);
    end
    blocked = 4'h0;
    enable = 1'b1;
    wait_pulse(60, ok);

    repeat (3) @(negedge Clk);
    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
